// File: rtl/weakbus_pkg.sv
// rtl/weakbus_pkg.sv - shared types and constants for the weakbus arbiter
// Contents: arbiter state enum, one-bit owner encoding, default error read data.
package weakbus_pkg;

    typedef enum logic {
        IDLE = 1'b0,
        BUSY = 1'b1
    } state_t;

    typedef logic owner_t;

    localparam owner_t OWNER_M0 = 1'b0;
    localparam owner_t OWNER_M1 = 1'b1;

    localparam logic [31:0] DEFAULT_ERR_DATA = 32'hDEAD_BEEF;

endpackage

// File: rtl/weakbus_watchdog.sv
// rtl/weakbus_watchdog.sv - saturating ownership watchdog for the weakbus arbiter
// Ports:
//   clk, rst (async active-low)
//   clear  : zero the count (a new grant)
//   enable : count this cycle (arbiter is BUSY)
//   expire : high in the enabled cycle whose count equals TIMEOUT-1
// TIMEOUT = 0 disables expiry entirely.
module weakbus_watchdog #(
    parameter int unsigned TIMEOUT = 255
) (
    input  logic clk,
    input  logic rst,
    input  logic clear,
    input  logic enable,
    output logic expire
);

    // A zero-width counter is illegal, so a disabled watchdog keeps one bit.
    localparam int unsigned CW = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
    localparam logic [CW-1:0] CNT_MAX  = '1;
    localparam logic [CW-1:0] CNT_ONE  = CW'(1);
    localparam logic [CW-1:0] CNT_LAST = (TIMEOUT > 0) ? CW'(TIMEOUT - 1) : '0;

    logic [CW-1:0] count;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            count <= '0;
        end else if (clear) begin
            count <= '0;
        end else if (enable && (count != CNT_MAX)) begin
            count <= count + CNT_ONE;
        end
    end

    assign expire = (TIMEOUT != 0) && enable && (count == CNT_LAST);

endmodule

// File: rtl/weakbus_arbiter.sv
// rtl/weakbus_arbiter.sv - two-master round-robin arbiter with timeout watchdog
// Ports:
//   clk, rst (async active-low)
//   m0_bus_*/m1_bus_* : master request side (req/addr/wr/out in, in/ack out)
//   s_bus_*           : slave side (req/addr/wr/out out, in/ack in)
//   timeout_err       : sticky forced-completion flag, err_clr clears it
module weakbus_arbiter
    import weakbus_pkg::*;
#(
    parameter int unsigned TIMEOUT  = 255,
    parameter logic [31:0] ERR_DATA = DEFAULT_ERR_DATA
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        m0_bus_req,
    input  logic [31:0] m0_bus_addr,
    input  logic        m0_bus_wr,
    input  logic [31:0] m0_bus_out,
    output logic [31:0] m0_bus_in,
    output logic        m0_bus_ack,
    input  logic        m1_bus_req,
    input  logic [31:0] m1_bus_addr,
    input  logic        m1_bus_wr,
    input  logic [31:0] m1_bus_out,
    output logic [31:0] m1_bus_in,
    output logic        m1_bus_ack,
    output logic        s_bus_req,
    output logic [31:0] s_bus_addr,
    output logic        s_bus_wr,
    output logic [31:0] s_bus_out,
    input  logic [31:0] s_bus_in,
    input  logic        s_bus_ack,
    output logic        timeout_err,
    input  logic        err_clr
);

    state_t      state, state_nxt;
    owner_t      owner, owner_nxt;
    owner_t      last, last_nxt;
    logic        grant;
    logic        busy;
    logic        expire;
    logic        fin;
    logic        forced;
    logic [31:0] rdata;

    assign busy   = (state == BUSY);
    // A real slave ack in the expiry cycle takes precedence over the timeout.
    assign fin    = busy && (s_bus_ack || expire);
    assign forced = busy && expire && !s_bus_ack;
    assign rdata  = s_bus_ack ? s_bus_in : ERR_DATA;

    weakbus_watchdog #(
        .TIMEOUT (TIMEOUT)
    ) u_watchdog (
        .clk    (clk),
        .rst    (rst),
        .clear  (grant),
        .enable (busy),
        .expire (expire)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= IDLE;
            owner <= OWNER_M0;
            last  <= OWNER_M1;
        end else begin
            state <= state_nxt;
            owner <= owner_nxt;
            last  <= last_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        owner_nxt = owner;
        last_nxt  = last;
        grant     = 1'b0;
        case (state)
            IDLE: begin
                // s_bus_ack seen here is a late ack after a timeout; ignored.
                if (m0_bus_req || m1_bus_req) begin
                    grant     = 1'b1;
                    state_nxt = BUSY;
                    if (m0_bus_req && m1_bus_req) begin
                        owner_nxt = ~last;
                    end else if (m1_bus_req) begin
                        owner_nxt = OWNER_M1;
                    end else begin
                        owner_nxt = OWNER_M0;
                    end
                    last_nxt = owner_nxt;
                end
            end
            BUSY: begin
                if (fin) begin
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        s_bus_req  = busy;
        s_bus_addr = '0;
        s_bus_wr   = 1'b0;
        s_bus_out  = '0;
        if (busy) begin
            s_bus_addr = (owner == OWNER_M1) ? m1_bus_addr : m0_bus_addr;
            s_bus_wr   = (owner == OWNER_M1) ? m1_bus_wr   : m0_bus_wr;
            s_bus_out  = (owner == OWNER_M1) ? m1_bus_out  : m0_bus_out;
        end
        m0_bus_ack = fin && (owner == OWNER_M0);
        m1_bus_ack = fin && (owner == OWNER_M1);
        m0_bus_in  = m0_bus_ack ? rdata : '0;
        m1_bus_in  = m1_bus_ack ? rdata : '0;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            timeout_err <= 1'b0;
        end else if (forced) begin
            timeout_err <= 1'b1;
        end else if (err_clr) begin
            timeout_err <= 1'b0;
        end
    end

endmodule

// File: tb/tb_weakbus_arbiter.sv
// tb/tb_weakbus_arbiter.sv - self-checking bench for weakbus_arbiter
module tb_weakbus_arbiter;

    localparam int unsigned TO  = 4;
    localparam logic [31:0] ERR = 32'hDEAD_BEEF;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        m0_bus_req = 1'b0, m1_bus_req = 1'b0;
    logic [31:0] m0_bus_addr = '0, m1_bus_addr = '0;
    logic        m0_bus_wr = 1'b0, m1_bus_wr = 1'b0;
    logic [31:0] m0_bus_out = '0, m1_bus_out = '0;
    logic [31:0] m0_bus_in, m1_bus_in;
    logic        m0_bus_ack, m1_bus_ack;
    logic        s_bus_req;
    logic [31:0] s_bus_addr;
    logic        s_bus_wr;
    logic [31:0] s_bus_out;
    logic [31:0] s_bus_in = '0;
    logic        s_bus_ack = 1'b0;
    logic        timeout_err;
    logic        err_clr = 1'b0;

    int errors = 0;
    int checks = 0;

    weakbus_arbiter #(.TIMEOUT(TO), .ERR_DATA(ERR)) dut (
        .clk(clk), .rst(rst),
        .m0_bus_req(m0_bus_req), .m0_bus_addr(m0_bus_addr), .m0_bus_wr(m0_bus_wr),
        .m0_bus_out(m0_bus_out), .m0_bus_in(m0_bus_in), .m0_bus_ack(m0_bus_ack),
        .m1_bus_req(m1_bus_req), .m1_bus_addr(m1_bus_addr), .m1_bus_wr(m1_bus_wr),
        .m1_bus_out(m1_bus_out), .m1_bus_in(m1_bus_in), .m1_bus_ack(m1_bus_ack),
        .s_bus_req(s_bus_req), .s_bus_addr(s_bus_addr), .s_bus_wr(s_bus_wr),
        .s_bus_out(s_bus_out), .s_bus_in(s_bus_in), .s_bus_ack(s_bus_ack),
        .timeout_err(timeout_err), .err_clr(err_clr)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Reference model: who holds the bus, for how many cycles, who won last, error flag.
    bit          md_busy = 0;
    int          md_owner = 0;
    int          md_cycles = 0;
    int          md_last = 1;
    bit          md_err = 0;
    bit          e_sreq, e_swr, e_ack0, e_ack1, timed, done;
    logic [31:0] e_saddr, e_sout, e_in0, e_in1, data;
    int          pick;

    always @(negedge clk) begin
        e_sreq = 0; e_swr = 0; e_saddr = 0; e_sout = 0;
        e_ack0 = 0; e_ack1 = 0; e_in0 = 0; e_in1 = 0;
        timed = 0; done = 0; data = 0;
        if (rst && md_busy) begin
            e_sreq  = 1;
            e_saddr = (md_owner == 1) ? m1_bus_addr : m0_bus_addr;
            e_swr   = (md_owner == 1) ? m1_bus_wr   : m0_bus_wr;
            e_sout  = (md_owner == 1) ? m1_bus_out  : m0_bus_out;
            // The watchdog fires on the TO-th owned cycle.
            timed = (TO != 0) && (md_cycles + 1 == TO);
            done  = s_bus_ack || timed;
            data  = s_bus_ack ? s_bus_in : ERR;
            if (md_owner == 0) begin e_ack0 = done; e_in0 = done ? data : 0; end
            else               begin e_ack1 = done; e_in1 = done ? data : 0; end
        end
        check("s_side", {s_bus_req, s_bus_wr, s_bus_addr, s_bus_out}, {e_sreq, e_swr, e_saddr, e_sout});
        check("m0_resp", {m0_bus_ack, m0_bus_in}, {e_ack0, e_in0});
        check("m1_resp", {m1_bus_ack, m1_bus_in}, {e_ack1, e_in1});
        check("timeout_err", timeout_err, rst ? md_err : 1'b0);
        if (!rst) begin
            md_busy = 0; md_owner = 0; md_cycles = 0; md_last = 1; md_err = 0;
        end else begin
            if (md_busy) begin
                md_cycles++;
                if (done) md_busy = 0;
                if (timed && !s_bus_ack) md_err = 1;
                else if (err_clr) md_err = 0;
            end else begin
                if (err_clr) md_err = 0;
                if (m0_bus_req || m1_bus_req) begin
                    if (m0_bus_req && m1_bus_req) pick = 1 - md_last;
                    else pick = m1_bus_req ? 1 : 0;
                    md_busy = 1; md_owner = pick; md_last = pick; md_cycles = 0;
                end
            end
        end
    end

    task automatic do_reset();
        @(posedge clk);
        #3 rst = 1'b0;
        m0_bus_req = 0; m1_bus_req = 0; s_bus_ack = 0; err_clr = 0;
        @(negedge clk);
        tick();
        rst = 1'b1;
    endtask

    bit a0, a1;

    initial begin
        // Reset state
        @(negedge clk);
        check("rst_sreq", s_bus_req, 1'b0);
        check("rst_acks", {m0_bus_ack, m1_bus_ack}, 2'b00);
        check("rst_err", timeout_err, 1'b0);
        tick();
        rst = 1'b1;

        // Single read by m0, slave acks in first BUSY cycle
        tick();
        m0_bus_req = 1; m0_bus_addr = 32'h100; m0_bus_wr = 0;
        s_bus_ack = 1; s_bus_in = 32'h1234_5678;
        @(negedge clk);
        check("rd_arb_noack", m0_bus_ack, 1'b0);
        tick();
        @(negedge clk);
        check("rd_ack", m0_bus_ack, 1'b1);
        check("rd_data", m0_bus_in, 32'h1234_5678);
        check("rd_addr", s_bus_addr, 32'h100);
        check("rd_m1_quiet", m1_bus_ack, 1'b0);
        tick();
        m0_bus_req = 0; s_bus_ack = 0;

        // Tie right after reset: m0, m1, m0, m1
        do_reset();
        m0_bus_req = 1; m0_bus_addr = 32'hA0;
        m1_bus_req = 1; m1_bus_addr = 32'hB0;
        s_bus_ack = 1; s_bus_in = 32'h42;
        for (int k = 0; k < 8; k++) begin
            @(negedge clk);
            check("tie_sreq", s_bus_req, (k % 2 == 1));
            if (k % 2 == 1) begin
                check("tie_addr", s_bus_addr, ((k / 2) % 2 == 1) ? 32'hB0 : 32'hA0);
                check("tie_ack", {m0_bus_ack, m1_bus_ack}, ((k / 2) % 2 == 1) ? 2'b01 : 2'b10);
            end
            tick();
        end
        m0_bus_req = 0; m1_bus_req = 0; s_bus_ack = 0;

        // Write pass-through by m1, slave acks on third BUSY cycle
        tick();
        m1_bus_req = 1; m1_bus_wr = 1; m1_bus_addr = 32'h2000; m1_bus_out = 32'hCAFE_F00D;
        @(negedge clk);
        for (int j = 0; j < 3; j++) begin
            tick();
            s_bus_ack = (j == 2);
            @(negedge clk);
            check("wr_fields", {s_bus_req, s_bus_wr, s_bus_addr, s_bus_out},
                  {1'b1, 1'b1, 32'h2000, 32'hCAFE_F00D});
            check("wr_ack", m1_bus_ack, (j == 2));
        end
        tick();
        m1_bus_req = 0; m1_bus_wr = 0; s_bus_ack = 0;

        // Timeout with silent slave, late ack, then clear
        tick();
        m0_bus_req = 1; m0_bus_addr = 32'h300;
        @(negedge clk);
        for (int j = 0; j < 4; j++) begin
            tick();
            @(negedge clk);
            check("to_ack", m0_bus_ack, (j == 3));
            check("to_err_pending", timeout_err, 1'b0);
            if (j == 3) check("to_data", m0_bus_in, ERR);
        end
        tick();
        m0_bus_req = 0; s_bus_ack = 1; s_bus_in = 32'h777;
        @(negedge clk);
        check("to_err_set", timeout_err, 1'b1);
        check("late_ack_ignored", {m0_bus_ack, m1_bus_ack, s_bus_req}, 3'b000);
        tick();
        s_bus_ack = 0; err_clr = 1;
        tick();
        err_clr = 0;
        @(negedge clk);
        check("err_cleared", timeout_err, 1'b0);

        // Real ack in the expiry cycle beats the timeout
        tick();
        m0_bus_req = 1;
        @(negedge clk);
        for (int j = 0; j < 4; j++) begin
            tick();
            s_bus_ack = (j == 3); s_bus_in = 32'h55;
            @(negedge clk);
        end
        check("race_ack", m0_bus_ack, 1'b1);
        check("race_data", m0_bus_in, 32'h55);
        tick();
        m0_bus_req = 0; s_bus_ack = 0;
        @(negedge clk);
        check("race_no_err", timeout_err, 1'b0);

        // Asynchronous reset in the middle of BUSY
        tick();
        m0_bus_req = 1;
        @(posedge clk);
        #3;
        check("pre_rst_busy", s_bus_req, 1'b1);
        rst = 1'b0;
        #1;
        check("arst_sreq_drop", s_bus_req, 1'b0);
        check("arst_no_ack", {m0_bus_ack, m1_bus_ack}, 2'b00);
        m0_bus_req = 0;
        tick();
        rst = 1'b1;
        m1_bus_req = 1; m1_bus_addr = 32'h400; s_bus_ack = 1; s_bus_in = 32'h9;
        tick();
        @(negedge clk);
        check("post_rst_grant", {s_bus_req, s_bus_addr}, {1'b1, 32'h400});
        check("post_rst_ack", m1_bus_ack, 1'b1);
        tick();
        m1_bus_req = 0; s_bus_ack = 0;

        // Randomized traffic against the model
        for (int c = 0; c < 3000; c++) begin
            @(negedge clk);
            a0 = m0_bus_ack; a1 = m1_bus_ack;
            tick();
            if (!m0_bus_req || a0) begin
                m0_bus_req  = $urandom_range(0, 1);
                m0_bus_addr = $urandom; m0_bus_wr = $urandom_range(0, 1); m0_bus_out = $urandom;
            end
            if (!m1_bus_req || a1) begin
                m1_bus_req  = $urandom_range(0, 1);
                m1_bus_addr = $urandom; m1_bus_wr = $urandom_range(0, 1); m1_bus_out = $urandom;
            end
            s_bus_ack = ($urandom_range(0, 4) < 2);
            s_bus_in  = $urandom;
            err_clr   = ($urandom_range(0, 7) == 0);
        end
        tick();
        m0_bus_req = 0; m1_bus_req = 0; s_bus_ack = 0; err_clr = 0;
        @(negedge clk);
        tick();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
